// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect
// input from later stages, and the IF/ID register handshake.
interface fetch_stage_if #(
  parameter int PC_SIZE   = 32,
  parameter int INST_SIZE = 32
);
  logic                 redirect_valid;
  logic [PC_SIZE-1:0]   redirect_pc;
  logic                 imem_req_valid;
  logic [PC_SIZE-1:0]   imem_req_addr;
  logic                 imem_req_ready;
  logic                 imem_resp_valid;
  logic [INST_SIZE-1:0] imem_resp_data;
  logic [PC_SIZE-1:0]   IF_PCplus4_out;
  logic [INST_SIZE-1:0] IF_inst_out;
  logic                 IF_valid_out;
  logic                 id_ready;

  // Fetch stage side
  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
           imem_resp_data, id_ready,
    output imem_req_valid, imem_req_addr, IF_PCplus4_out, IF_inst_out,
           IF_valid_out
  );

  // Memory / pipeline side
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
           imem_resp_data, id_ready,
    input  imem_req_valid, imem_req_addr, IF_PCplus4_out, IF_inst_out,
           IF_valid_out
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request at a time,
// buffers the returned word for the IF/ID register, and honours redirects
// from later stages (discarding any response that belongs to the old path).
module fetch_stage #(
  parameter int                 PC_SIZE   = 32,
  parameter int                 INST_SIZE = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  // REQ: issue request; WAIT: request accepted, awaiting word;
  // HOLD: word presented to ID; FLUSH: awaiting a stale word to drop.
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FLUSH} state_t;

  state_t               state_q, state_d;
  logic [PC_SIZE-1:0]   pc_q, pc_d;
  logic [PC_SIZE-1:0]   pcp4_q, pcp4_d;
  logic [INST_SIZE-1:0] inst_q, inst_d;
  logic [PC_SIZE-1:0]   pc_plus4;
  logic [PC_SIZE-1:0]   redirect_aligned;

  // Natural-width add wraps modulo 2^PC_SIZE
  assign pc_plus4         = pc_q + PC_SIZE'(4);
  assign redirect_aligned = {bus.redirect_pc[PC_SIZE-1:2], 2'b00};

  // State and buffer registers; reset overrides redirect and handshakes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      pcp4_q  <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcp4_q  <= pcp4_d;
      inst_q  <= inst_d;
    end
  end

  // Next-state, pc and buffer update; redirect wins over every other event
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pcp4_d  = pcp4_q;
    inst_d  = inst_q;
    unique case (state_q)
      S_REQ: begin
        if (!bus.redirect_valid && bus.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          // A same-cycle response belongs to the old path: drop it now,
          // otherwise remember that the next one must be dropped.
          state_d = bus.imem_resp_valid ? S_REQ : S_FLUSH;
        end else if (bus.imem_resp_valid) begin
          state_d = S_HOLD;
          inst_d  = bus.imem_resp_data;
          pcp4_d  = pc_plus4;
          pc_d    = pc_plus4;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid || bus.id_ready) state_d = S_REQ;
      end
      S_FLUSH: begin
        if (bus.imem_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (bus.redirect_valid) pc_d = redirect_aligned;
  end

  // Outputs: request only from REQ, never during reset or a redirect cycle
  always_comb begin
    bus.imem_req_valid = !reset && (state_q == S_REQ) && !bus.redirect_valid;
    bus.imem_req_addr  = {pc_q[PC_SIZE-1:2], 2'b00};
    bus.IF_valid_out   = (state_q == S_HOLD);
    bus.IF_inst_out    = inst_q;
    bus.IF_PCplus4_out = pcp4_q;
  end

endmodule
